// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and owner ids.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory_controller port between the L1I and
// L1D paths, one transaction at a time, with a wait-cycle watchdog.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on simultaneous
// requests; when undefined, L1D always wins).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall_l1i,
  output logic                  stall_l1d,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  timeout_err
);

  // Counter only needs to reach MAX_WAIT-1.
  localparam int CNT_W = $clog2(MAX_WAIT);

  arb_state_t       state;
  arb_state_t       next_state;
  owner_t           owner;
  owner_t           grant;
  logic             write_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             any_req;
  logic             expire;
  logic             complete;
  logic             abort;

  assign any_req = i_req | d_req;
  assign expire  = (wait_cnt == CNT_W'(MAX_WAIT - 1));

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner;

  // Remember who was granted last so a tie goes to the other side next time.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_owner <= OWNER_I;
    end else if (state == ARB_IDLE && any_req) begin
      last_owner <= grant;
    end
  end
`endif

  // Pick the next owner from the requests present in IDLE.
  always_comb begin
    grant = OWNER_D;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
`else
      grant = OWNER_D;
`endif
    end else if (i_req) begin
      grant = OWNER_I;
    end
  end

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a completion or a watchdog expiry both return to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: if (any_req) next_state = ARB_BUSY;
      ARB_BUSY: if (mem_ready || expire) next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // Latch the granted transaction so the memory port sees stable fields in BUSY.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner     <= OWNER_I;
      mem_addr  <= '0;
      mem_wdata <= '0;
      write_q   <= 1'b0;
    end else if (state == ARB_IDLE && any_req) begin
      owner     <= grant;
      mem_addr  <= (grant == OWNER_D) ? d_addr : i_addr;
      mem_wdata <= (grant == OWNER_D) ? d_wdata : '0;
      write_q   <= (grant == OWNER_D) && d_write;
    end
  end

  // Watchdog counter: zero on entry to BUSY, counts every BUSY cycle.
  always_ff @(posedge clock) begin
    if (reset || state == ARB_IDLE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Completion wins over a simultaneous expiry; nothing completes during reset.
  always_comb begin
    complete    = (state == ARB_BUSY) && mem_ready && !reset;
    abort       = (state == ARB_BUSY) && expire && !mem_ready && !reset;
    mem_req     = (state == ARB_BUSY);
    mem_write   = write_q && (owner == OWNER_D);
    i_done      = (complete || abort) && (owner == OWNER_I);
    d_done      = (complete || abort) && (owner == OWNER_D);
    timeout_err = abort;
    rdata       = complete ? mem_rdata : '0;
    stall_l1i   = i_req & ~i_done;
    stall_l1d   = d_req & ~d_done;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_WAIT = 8).
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] rdata;
  logic        stall_l1i;
  logic        stall_l1d;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_WAIT  (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_done     (i_done),
    .d_req      (d_req),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_done     (d_done),
    .rdata      (rdata),
    .stall_l1i  (stall_l1i),
    .stall_l1d  (stall_l1d),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    clear_inputs();
    i_req   = 1'b1;
    i_addr  = 32'h0000_0ABC;
    next_cycle();
    next_cycle();
    @(negedge clock);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %0h expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 00000000", mem_wdata); end
    checks++; if ({mem_write, i_done, d_done, timeout_err} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {mem_write, i_done, d_done, timeout_err}); end
    next_cycle();
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    i_req  = 1'b1;
    i_addr = 32'h0000_0100;
    @(negedge clock);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rd_c0_mem_req: got %0h expected 0", mem_req); end
    checks++; if (stall_l1i !== 1'b1) begin errors++; $display("[TB] FAIL rd_c0_stall: got %0h expected 1", stall_l1i); end
    next_cycle();
    @(negedge clock);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rd_c1_mem_req: got %0h expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL rd_c1_mem_addr: got %h expected 00000100", mem_addr); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL rd_c1_mem_write: got %0h expected 0", mem_write); end
    next_cycle();
    @(negedge clock);
    checks++; if (i_done !== 1'b0) begin errors++; $display("[TB] FAIL rd_c2_i_done: got %0h expected 0", i_done); end
    next_cycle();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    checks++; if (i_done !== 1'b1) begin errors++; $display("[TB] FAIL rd_c3_i_done: got %0h expected 1", i_done); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_c3_rdata: got %h expected deadbeef", rdata); end
    checks++; if ({d_done, timeout_err, stall_l1i} !== 3'b000) begin errors++; $display("[TB] FAIL rd_c3_flags: got %b expected 000", {d_done, timeout_err, stall_l1i}); end
    next_cycle();
    i_req     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clock);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rd_c4_idle: got %0h expected 0", mem_req); end
  endtask

  task automatic test_store();
    do_reset();
    d_req   = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_2000;
    d_wdata = 32'h0000_0055;
    next_cycle();
    @(negedge clock);
    checks++; if ({mem_req, mem_write} !== 2'b11) begin errors++; $display("[TB] FAIL st_req_write: got %b expected 11", {mem_req, mem_write}); end
    checks++; if (mem_addr !== 32'h0000_2000) begin errors++; $display("[TB] FAIL st_mem_addr: got %h expected 00002000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0000_0055) begin errors++; $display("[TB] FAIL st_mem_wdata: got %h expected 00000055", mem_wdata); end
    checks++; if (stall_l1d !== 1'b1) begin errors++; $display("[TB] FAIL st_stall: got %0h expected 1", stall_l1d); end
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clock);
    checks++; if ({d_done, i_done} !== 2'b10) begin errors++; $display("[TB] FAIL st_done: got %b expected 10", {d_done, i_done}); end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL st_idle: got %0h expected 0", mem_req); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d_seq;
    logic       exp_d;
`ifdef ARB_ROUND_ROBIN_EN
    exp_d_seq = 4'b0101;
`else
    exp_d_seq = 4'b1111;
`endif
    do_reset();
    i_req  = 1'b1;
    d_req  = 1'b1;
    i_addr = 32'h0000_0300;
    d_addr = 32'h0000_0400;
    for (int t = 0; t < 4; t++) begin
      @(negedge clock);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_%0d: got %0h expected 0", t, mem_req); end
      next_cycle();
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_1000 + 32'(t);
      exp_d     = exp_d_seq[t];
      @(negedge clock);
      checks++; if ({d_done, i_done} !== {exp_d, ~exp_d}) begin errors++; $display("[TB] FAIL b2b_owner_%0d: got d/i=%b expected %b", t, {d_done, i_done}, {exp_d, ~exp_d}); end
      checks++; if (mem_addr !== (exp_d ? 32'h0000_0400 : 32'h0000_0300)) begin errors++; $display("[TB] FAIL b2b_addr_%0d: got %h expected %h", t, mem_addr, (exp_d ? 32'h0000_0400 : 32'h0000_0300)); end
      checks++; if ({stall_l1i, stall_l1d} !== {exp_d, ~exp_d}) begin errors++; $display("[TB] FAIL b2b_stall_%0d: got %b expected %b", t, {stall_l1i, stall_l1d}, {exp_d, ~exp_d}); end
      next_cycle();
      mem_ready = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    d_req     = 1'b1;
    d_addr    = 32'h0000_0800;
    mem_rdata = 32'hFFFF_FFFF;
    next_cycle();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k < 8) begin
        checks++; if ({mem_req, d_done, timeout_err} !== 3'b100) begin errors++; $display("[TB] FAIL wd_wait_%0d: got %b expected 100", k, {mem_req, d_done, timeout_err}); end
      end else begin
        checks++; if ({d_done, timeout_err, i_done} !== 3'b110) begin errors++; $display("[TB] FAIL wd_expire: got %b expected 110", {d_done, timeout_err, i_done}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL wd_rdata: got %h expected 00000000", rdata); end
      end
      next_cycle();
    end
    d_req = 1'b0;
    @(negedge clock);
    checks++; if ({mem_req, timeout_err} !== 2'b00) begin errors++; $display("[TB] FAIL wd_idle: got %b expected 00", {mem_req, timeout_err}); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_ready_at_expiry();
    do_reset();
    d_req  = 1'b1;
    d_addr = 32'h0000_0900;
    next_cycle();
    for (int k = 1; k < 8; k++) next_cycle();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    checks++; if ({d_done, timeout_err} !== 2'b10) begin errors++; $display("[TB] FAIL rx_done_tmo: got %b expected 10", {d_done, timeout_err}); end
    checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL rx_rdata: got %h expected cafef00d", rdata); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_in_busy();
    do_reset();
    i_req  = 1'b1;
    i_addr = 32'h0000_0500;
    next_cycle();
    @(negedge clock);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rb_busy1: got %0h expected 1", mem_req); end
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (i_done !== 1'b0) begin errors++; $display("[TB] FAIL rb_no_done: got %0h expected 0", i_done); end
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({mem_req, i_done} !== 2'b00) begin errors++; $display("[TB] FAIL rb_dropped: got %b expected 00", {mem_req, i_done}); end
    next_cycle();
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_1234;
    @(negedge clock);
    checks++; if ({mem_req, i_done} !== 2'b11) begin errors++; $display("[TB] FAIL rb_regrant: got %b expected 11", {mem_req, i_done}); end
    checks++; if (mem_addr !== 32'h0000_0500) begin errors++; $display("[TB] FAIL rb_addr: got %h expected 00000500", mem_addr); end
    checks++; if (rdata !== 32'h0000_1234) begin errors++; $display("[TB] FAIL rb_rdata: got %h expected 00001234", rdata); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_ready_in_idle();
    do_reset();
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_ABCD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++; if ({mem_req, i_done, d_done, timeout_err} !== 4'b0000) begin errors++; $display("[TB] FAIL idle_ready_%0d: got %b expected 0000", k, {mem_req, i_done, d_done, timeout_err}); end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_store();
    test_back_to_back();
    test_watchdog();
    test_ready_at_expiry();
    test_reset_in_busy();
    test_ready_in_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
